// File: rtl/arb_requester.sv
// Requester-side agent for a 4-way request/grant arbiter: buffers local writes
// in a FIFO, requests the bus once a burst is ready and streams it on grant.
module arb_requester #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              rqst,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              timeout_err,
  output logic              busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST_LEN);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    blen_q, blen_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WAIT_W-1:0]   wait_inc;
  logic                rqst_q, rqst_d;
  logic                busy_q, busy_d;
  logic                tout_q, tout_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q;
  logic                push, pop;

  // ---------------- FIFO ----------------
  // A write while full is dropped even if a beat frees a slot in the same cycle.
  assign push = wr_en && !full_q;
  assign pop  = bus_valid;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!push && pop)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      blen_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rqst_q  <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rqst_q  <= rqst_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  // ---------------- FSM: next state ----------------
  assign wait_inc = wait_q + WAIT_W'(1);

  always_comb begin
    state_d = state_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    tout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Burst length is frozen here; later pushes wait for the next burst.
        if (count_q >= BURST_C) begin
          state_d = S_REQ;
          blen_d  = BURST_C;
          wait_d  = '0;
        end else if (flush && count_q != '0) begin
          state_d = S_REQ;
          blen_d  = count_q;
          wait_d  = '0;
        end
      end
      S_REQ: begin
        if (grant) begin
          state_d = S_XFER;
          beat_d  = '0;
        end else if (wait_inc == TIMEOUT_C) begin
          state_d = S_RELEASE;
          tout_d  = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_XFER: begin
        if (!grant) begin
          state_d = S_RELEASE;
        end else begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == blen_q - CNT_W'(1))
            state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus_valid = (state_q == S_XFER) && grant;
    bus_last  = bus_valid && (beat_q == blen_q - CNT_W'(1));
    bus_data  = mem_q[rd_ptr_q];
    rqst_d    = (state_d == S_REQ) || (state_d == S_XFER);
    busy_d    = (state_d != S_IDLE);
  end

  assign full        = full_q;
  assign rqst        = rqst_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;

endmodule
